vscale_dmem_responder: RTL and testbench

Data-memory responder for the vscale core's two-phase dmem bus. It accepts address-phase requests from the pipeline and completes each one in a following data phase: it samples write data, returns load data, stretches the phase with wait states and flags bad accesses. It holds a word-organised internal memory with per-byte-lane writes, and takes the place of the testbench or SoC memory model on the core's dmem port.

---
 rtl/vscale_dmem_responder_if.sv | 21 ++
 rtl/vscale_dmem_responder.sv | 125 ++++++++++++
 tb/tb_vscale_dmem_responder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/vscale_dmem_responder_if.sv
// Two-phase vscale dmem bus: the requester (master) drives address/store data, the responder answers.
interface vscale_dmem_responder_if;
   logic        dmem_en;
   logic        dmem_wen;
   logic [2:0]  dmem_size;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata_delayed;
   logic [31:0] dmem_rdata;
   logic        dmem_wait;
   logic        dmem_badmem_e;

   modport master (
      output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
      input  dmem_rdata, dmem_wait, dmem_badmem_e
   );

   modport slave (
      input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
      output dmem_rdata, dmem_wait, dmem_badmem_e
   );
endinterface

// File: rtl/vscale_dmem_responder.sv
// Data-memory responder for the vscale two-phase dmem bus, backed by a byte-lane-writable word array.
// Good accesses take WAIT_CYCLES+1 data-phase cycles, bad ones one; dmem_wait stalls the requester meanwhile.
module vscale_dmem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 0
) (
   input logic                    clk,
   input logic                    reset,
   vscale_dmem_responder_if.slave dmem
);
   localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
   localparam logic [2:0]  SIZE_B    = 3'd0;
   localparam logic [2:0]  SIZE_H    = 3'd1;
   localparam logic [2:0]  SIZE_W    = 3'd2;

   typedef enum logic [1:0] {IDLE, DATA, LAST} state_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             wen_q, wen_d;
   logic [2:0]       size_q, size_d;
   logic [1:0]       lane_q, lane_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             bad_q, bad_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0] offset;
   logic        out_of_range;
   logic        misaligned;
   logic        bad_size;
   logic        req_bad;
   logic        accept;
   logic        commit;
   logic [3:0]  strb;

   // BASE_ADDR is span-aligned, so the offset's low bits are the byte lane.
   assign offset       = dmem.dmem_addr - BASE_ADDR;
   assign out_of_range = offset >= SPAN;
   assign misaligned   = ((dmem.dmem_size == SIZE_H) && offset[0]) ||
                         ((dmem.dmem_size == SIZE_W) && (offset[1:0] != 2'b00));
   assign bad_size     = dmem.dmem_size > SIZE_W;
   assign req_bad      = out_of_range | misaligned | bad_size;
   assign accept       = dmem.dmem_en && (state_q != DATA);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wen_d   = wen_q;
      size_d  = size_q;
      lane_d  = lane_q;
      idx_d   = idx_q;
      bad_d   = bad_q;
      case (state_q)
         DATA: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = LAST;
         end
         LAST:    state_d = IDLE;
         default: state_d = state_q;
      endcase
      // A new request in LAST overrides the return to IDLE: no bubble between transfers.
      if (accept) begin
         wen_d  = dmem.dmem_wen;
         size_d = dmem.dmem_size;
         lane_d = offset[1:0];
         idx_d  = offset[IDX_W+1:2];
         bad_d  = req_bad;
         if (!req_bad && (WAIT_INIT != 4'd0)) begin
            state_d = DATA;
            cnt_d   = WAIT_INIT;
         end else begin
            state_d = LAST;
         end
      end
   end

   always_comb begin
      strb = 4'b1111;
      case (size_q)
         SIZE_B:  strb = 4'b0001 << lane_q;
         SIZE_H:  strb = lane_q[1] ? 4'b1100 : 4'b0011;
         default: strb = 4'b1111;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wen_q   <= 1'b0;
         size_q  <= '0;
         lane_q  <= '0;
         idx_q   <= '0;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wen_q   <= wen_d;
         size_q  <= size_d;
         lane_q  <= lane_d;
         idx_q   <= idx_d;
         bad_q   <= bad_d;
      end
   end

   // Reset in LAST discards the store.
   assign commit = (state_q == LAST) && wen_q && !bad_q && !reset;

   always_ff @(posedge clk) begin
      if (commit) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) mem[idx_q][8*b +: 8] <= dmem.dmem_wdata_delayed[8*b +: 8];
         end
      end
   end

   assign dmem.dmem_wait     = (state_q == DATA);
   assign dmem.dmem_badmem_e = (state_q == LAST) && bad_q;
   assign dmem.dmem_rdata    = ((state_q == LAST) && !wen_q && !bad_q) ? mem[idx_q] : 32'h0;

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Bench for vscale_dmem_responder: table of back-to-back transfers with W=0, plus wait-state and reset sequences.
module tb_vscale_dmem_responder;
   logic clk;
   logic rst0, rst3, rst2;

   vscale_dmem_responder_if bus0();
   vscale_dmem_responder_if bus3();
   vscale_dmem_responder_if bus2();

   vscale_dmem_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_CYCLES(0))
      u_w0 (.clk(clk), .reset(rst0), .dmem(bus0));
   vscale_dmem_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_CYCLES(3))
      u_w3 (.clk(clk), .reset(rst3), .dmem(bus3));
   vscale_dmem_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_CYCLES(2))
      u_w2 (.clk(clk), .reset(rst2), .dmem(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wen;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_bad;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        bad;
      int          id;
   } exp_t;

   localparam int NV = 25;
   vec_t tbl [NV];
   exp_t sbq [$];
   exp_t e;
   int   checks;
   int   errors;
   int   n;

   function automatic vec_t mk(input logic wen, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_bad);
      vec_t v;
      v.wen = wen; v.size = size; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_bad = exp_bad;
      return v;
   endfunction

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic check1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic idle_check(input string nm, input logic w, input logic b, input logic [31:0] r);
      check1({nm, " wait"}, w, 1'b0);
      check1({nm, " badmem"}, b, 1'b0);
      check32({nm, " rdata"}, r, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      {bus0.dmem_en, bus0.dmem_wen, bus0.dmem_size, bus0.dmem_addr, bus0.dmem_wdata_delayed} = '0;
      {bus3.dmem_en, bus3.dmem_wen, bus3.dmem_size, bus3.dmem_addr, bus3.dmem_wdata_delayed} = '0;
      {bus2.dmem_en, bus2.dmem_wen, bus2.dmem_size, bus2.dmem_addr, bus2.dmem_wdata_delayed} = '0;
      rst0 = 1'b1; rst3 = 1'b1; rst2 = 1'b1;

      //             wen   size  addr        wdata         exp_rdata     bad
      tbl[0]  = mk(1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0);
      tbl[1]  = mk(1'b0, 3'd2, 32'h10,   32'hFFFFFFFF, 32'hDEADBEEF, 1'b0);
      tbl[2]  = mk(1'b1, 3'd2, 32'h10,   32'h11223344, 32'h0,        1'b0);
      tbl[3]  = mk(1'b1, 3'd0, 32'h13,   32'h5A5A5A5A, 32'h0,        1'b0);
      tbl[4]  = mk(1'b0, 3'd2, 32'h10,   32'hFFFFFFFF, 32'h5A223344, 1'b0);
      tbl[5]  = mk(1'b1, 3'd0, 32'h11,   32'hA5A5A5A5, 32'h0,        1'b0);
      tbl[6]  = mk(1'b0, 3'd2, 32'h10,   32'hFFFFFFFF, 32'h5A22A544, 1'b0);
      tbl[7]  = mk(1'b1, 3'd2, 32'h20,   32'h0BADF00D, 32'h0,        1'b0);
      tbl[8]  = mk(1'b1, 3'd1, 32'h21,   32'hFFFFFFFF, 32'h0,        1'b1);
      tbl[9]  = mk(1'b0, 3'd2, 32'h20,   32'hFFFFFFFF, 32'h0BADF00D, 1'b0);
      tbl[10] = mk(1'b0, 3'd2, 32'h1000, 32'hFFFFFFFF, 32'h0,        1'b1);
      tbl[11] = mk(1'b0, 3'd3, 32'h20,   32'hFFFFFFFF, 32'h0,        1'b1);
      tbl[12] = mk(1'b0, 3'd2, 32'h22,   32'hFFFFFFFF, 32'h0,        1'b1);
      tbl[13] = mk(1'b1, 3'd1, 32'h22,   32'hBEEFBEEF, 32'h0,        1'b0);
      tbl[14] = mk(1'b0, 3'd2, 32'h20,   32'hFFFFFFFF, 32'hBEEFF00D, 1'b0);
      tbl[15] = mk(1'b1, 3'd2, 32'h40,   32'h11111111, 32'h0,        1'b0);
      tbl[16] = mk(1'b1, 3'd2, 32'h44,   32'h22222222, 32'h0,        1'b0);
      tbl[17] = mk(1'b1, 3'd2, 32'h48,   32'h33333333, 32'h0,        1'b0);
      tbl[18] = mk(1'b0, 3'd2, 32'h40,   32'hFFFFFFFF, 32'h11111111, 1'b0);
      tbl[19] = mk(1'b0, 3'd2, 32'h44,   32'hFFFFFFFF, 32'h22222222, 1'b0);
      tbl[20] = mk(1'b0, 3'd2, 32'h48,   32'hFFFFFFFF, 32'h33333333, 1'b0);
      tbl[21] = mk(1'b0, 3'd1, 32'h42,   32'hFFFFFFFF, 32'h11111111, 1'b0);
      tbl[22] = mk(1'b0, 3'd0, 32'h43,   32'hFFFFFFFF, 32'h11111111, 1'b0);
      tbl[23] = mk(1'b1, 3'd2, 32'h1040, 32'hDEADDEAD, 32'h0,        1'b1);
      tbl[24] = mk(1'b0, 3'd2, 32'h40,   32'hFFFFFFFF, 32'h11111111, 1'b0);

      @(negedge clk);
      @(negedge clk);
      idle_check("reset w0", bus0.dmem_wait, bus0.dmem_badmem_e, bus0.dmem_rdata);
      idle_check("reset w3", bus3.dmem_wait, bus3.dmem_badmem_e, bus3.dmem_rdata);
      idle_check("reset w2", bus2.dmem_wait, bus2.dmem_badmem_e, bus2.dmem_rdata);
      rst0 = 1'b0; rst3 = 1'b0; rst2 = 1'b0;

      // W=0: one request per cycle; each data phase overlaps the next address phase.
      for (int i = 0; i <= NV; i++) begin
         @(negedge clk);
         if (i > 0) begin
            if (sbq.size() == 0) begin
               checks++; errors++;
               $display("FAIL w0 scoreboard[%0d]: got empty queue want one entry", i - 1);
            end else begin
               e = sbq.pop_front();
               check1($sformatf("w0 wait[%0d]", e.id), bus0.dmem_wait, 1'b0);
               check1($sformatf("w0 badmem[%0d]", e.id), bus0.dmem_badmem_e, e.bad);
               check32($sformatf("w0 rdata[%0d]", e.id), bus0.dmem_rdata, e.rdata);
            end
            bus0.dmem_wdata_delayed = tbl[i-1].wdata;
         end
         if (i < NV) begin
            bus0.dmem_en   = 1'b1;
            bus0.dmem_wen  = tbl[i].wen;
            bus0.dmem_size = tbl[i].size;
            bus0.dmem_addr = tbl[i].addr;
            sbq.push_back('{tbl[i].exp_rdata, tbl[i].exp_bad, i});
         end else begin
            bus0.dmem_en = 1'b0;
         end
      end
      @(negedge clk);
      idle_check("w0 idle", bus0.dmem_wait, bus0.dmem_badmem_e, bus0.dmem_rdata);

      // W=0: reset in the LAST cycle of a store must drop the write.
      bus0.dmem_en = 1'b1; bus0.dmem_wen = 1'b1; bus0.dmem_size = 3'd2; bus0.dmem_addr = 32'h40;
      @(negedge clk);
      bus0.dmem_wdata_delayed = 32'h77777777;
      bus0.dmem_en = 1'b0;
      rst0 = 1'b1;
      @(negedge clk);
      idle_check("w0 reset-in-last", bus0.dmem_wait, bus0.dmem_badmem_e, bus0.dmem_rdata);
      rst0 = 1'b0;
      bus0.dmem_en = 1'b1; bus0.dmem_wen = 1'b0; bus0.dmem_addr = 32'h40;
      @(negedge clk);
      bus0.dmem_en = 1'b0;
      check32("w0 load after dropped store", bus0.dmem_rdata, 32'h11111111);

      // W=3: store then back-to-back load, with junk on the address bus during the load's wait.
      @(negedge clk);
      bus3.dmem_en = 1'b1; bus3.dmem_wen = 1'b1; bus3.dmem_size = 3'd2; bus3.dmem_addr = 32'h10;
      bus3.dmem_wdata_delayed = 32'h600DCAFE;
      @(negedge clk);
      bus3.dmem_en = 1'b0;
      n = 0;
      while (bus3.dmem_wait && n < 20) begin n++; @(negedge clk); end
      check32("w3 store wait cycles", 32'(n), 32'd3);
      check1("w3 store badmem", bus3.dmem_badmem_e, 1'b0);
      check32("w3 store rdata", bus3.dmem_rdata, 32'h0);
      bus3.dmem_en = 1'b1; bus3.dmem_wen = 1'b0; bus3.dmem_addr = 32'h10;
      @(negedge clk);
      bus3.dmem_en = 1'b1; bus3.dmem_wen = 1'b1; bus3.dmem_size = 3'd0; bus3.dmem_addr = 32'h14;
      bus3.dmem_wdata_delayed = 32'hFFFFFFFF;
      n = 0;
      while (bus3.dmem_wait && n < 20) begin n++; @(negedge clk); end
      bus3.dmem_en = 1'b0;
      check32("w3 load wait cycles", 32'(n), 32'd3);
      check1("w3 load badmem", bus3.dmem_badmem_e, 1'b0);
      check32("w3 load rdata", bus3.dmem_rdata, 32'h600DCAFE);
      @(negedge clk);
      idle_check("w3 idle", bus3.dmem_wait, bus3.dmem_badmem_e, bus3.dmem_rdata);

      // W=2: seed 0x30, then reset during the second wait cycle of an overwriting store.
      bus2.dmem_en = 1'b1; bus2.dmem_wen = 1'b1; bus2.dmem_size = 3'd2; bus2.dmem_addr = 32'h30;
      bus2.dmem_wdata_delayed = 32'h12345678;
      @(negedge clk);
      bus2.dmem_en = 1'b0;
      n = 0;
      while (bus2.dmem_wait && n < 20) begin n++; @(negedge clk); end
      check32("w2 seed wait cycles", 32'(n), 32'd2);
      bus2.dmem_en = 1'b1; bus2.dmem_wen = 1'b1; bus2.dmem_addr = 32'h30;
      @(negedge clk);
      bus2.dmem_en = 1'b0;
      bus2.dmem_wdata_delayed = 32'hCAFEF00D;
      check1("w2 wait cycle 1", bus2.dmem_wait, 1'b1);
      @(negedge clk);
      check1("w2 wait cycle 2", bus2.dmem_wait, 1'b1);
      rst2 = 1'b1;
      @(negedge clk);
      idle_check("w2 after reset", bus2.dmem_wait, bus2.dmem_badmem_e, bus2.dmem_rdata);
      rst2 = 1'b0;
      @(negedge clk);
      bus2.dmem_en = 1'b1; bus2.dmem_wen = 1'b0; bus2.dmem_addr = 32'h30;
      @(negedge clk);
      bus2.dmem_en = 1'b0;
      n = 0;
      while (bus2.dmem_wait && n < 20) begin n++; @(negedge clk); end
      check32("w2 load wait cycles", 32'(n), 32'd2);
      check32("w2 load old data", bus2.dmem_rdata, 32'h12345678);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
